async_fifo_param: RTL and testbench
===================================

ASYNC_FIFO_PARAM -- requirements
Module: async_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words (ADDR_W >= 2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per crossing (>=2).
REQ-004 SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-005 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold (1..DEPTH).
REQ-006 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold (0..DEPTH-1).
REQ-007 Ports (name direction width meaning):
- wclk input 1 write clock
- wrst_n input 1 write-domain reset, asynchronous, active-low
- rclk input 1 read clock
- rrst_n input 1 read-domain reset, asynchronous, active-low
- winc input 1 write request
- wdata input DATA_W write data
- wfull output 1 FIFO full (wclk domain)
- walmost_full output 1 wlevel >= AF_LEVEL
- wlevel output ADDR_W+1 occupancy seen by write side
- woverflow output 1 one-cycle pulse: write attempted while full
- rinc input 1 read/pop request
- rdata output DATA_W read data
- rempty output 1 FIFO empty (rclk domain)
- ralmost_empty output 1 rlevel <= AE_LEVEL
- rlevel output ADDR_W+1 occupancy seen by read side
- runderflow output 1 one-cycle pulse: read attempted while empty

Function
REQ-008 Write accepted at wclk rise when winc && !wfull; wdata stored at mem[wbin[ADDR_W-1:0]]; wbin increments by 1 modulo 2**(ADDR_W+1).
REQ-009 Read accepted at rclk rise when rinc && !rempty; rbin increments by 1 modulo 2**(ADDR_W+1).
REQ-010 Pointers SHALL cross domains only as registered Gray code (ADDR_W+1 bits) through SYNC_STAGES flops; no binary or combinational signal crosses.
REQ-011 wfull SHALL be registered: set at the edge where next write Gray pointer equals synced read Gray pointer with top two bits inverted, rest equal.
REQ-012 rempty SHALL be registered: set at the edge where next read Gray pointer equals synced write Gray pointer.
REQ-013 wlevel SHALL be registered = wbin_next - bin(synced rptr), ADDR_W+1 bits; rlevel = bin(synced wptr) - rbin_next; both range 0..DEPTH.
REQ-014 walmost_full and ralmost_empty SHALL update on the same edge as wlevel/rlevel, from the same next-state values.
REQ-015 woverflow SHALL pulse for one wclk cycle when winc && wfull; write is dropped, no state changes.
REQ-016 runderflow SHALL pulse for one rclk cycle when rinc && rempty; pointer and rdata unchanged.
REQ-017 FWFT=0: rdata SHALL load mem[raddr] at the accepting rclk edge (1-cycle latency) and hold otherwise.
REQ-018 FWFT=1: rdata SHALL equal the head word whenever rempty=0, and 0 when rempty=1; rinc pops the head.
REQ-019 A write SHALL clear rempty no earlier than SYNC_STAGES+1 and no later than SYNC_STAGES+2 rclk edges after the committing wclk edge; a read likewise releases wfull in wclk edges.
REQ-020 Simultaneous write and read in a full or empty FIFO SHALL follow REQ-008/009 independently; full/empty flags are pessimistic, never optimistic.
REQ-021 Data SHALL be returned in strict write order with no loss or duplication across pointer wrap-around.

Reset
REQ-022 wrst_n low SHALL immediately clear wbin, wptr, write-side synchronisers, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
REQ-023 rrst_n low SHALL immediately clear rbin, rptr, read-side synchronisers, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0, rdata=0.
REQ-024 Flush SHALL require both resets asserted together; contents discarded, first post-reset write lands at address 0; memory array not reset.

Verification
REQ-025 Both resets low, release -> rempty=1, wfull=0, wlevel=rlevel=0, rdata=0x00, ralmost_empty=1.
REQ-026 Defaults, wclk 10 ns, rclk 14 ns; write 0x00..0x0F no reads -> wfull at 16th write edge, wlevel=16; write 0xAA -> woverflow 1 cycle, dropped; read 16 -> 0x00..0x0F, rempty after 16th pop; extra rinc -> runderflow pulse, rdata holds 0x0F.
REQ-027 AF_LEVEL=12: 12 writes -> walmost_full at 12th write edge; 1 read -> walmost_full clears within SYNC_STAGES+2 wclk edges, wlevel=11.
REQ-028 FWFT=1: write 0x5A -> rdata=0x5A, rempty=0 without rinc; rinc -> rempty=1, rdata=0x00.
REQ-029 Random streaming, 1000 words, wclk 7 ns / rclk 11 ns, writer gated by wfull, reader by rempty -> order exact, no overflow/underflow pulses, >=60 pointer wraps.
REQ-030 7 words queued, both resets pulsed mid-operation -> rempty=1, wlevel=0; write 0x33 then read -> 0x33 first.

Source files
------------

// File: rtl/async_fifo_param.sv
// Dual-clock FIFO: Gray-coded pointers cross through flop synchronisers, flags and
// levels are registered per domain, and the read port is registered or fall-through.
`timescale 1ns/1ps

module async_fifo_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];
endmodule

module async_fifo_wptr #(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_sync,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W-1:0] waddr,
    output logic              wen,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              woverflow
);
    localparam logic [ADDR_W:0] AF_THR = AF_LEVEL[ADDR_W:0];

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rbin_sync;
    logic [ADDR_W:0] level_next;
    logic            full_next;

    function automatic logic [ADDR_W:0] gray_to_bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign wen        = winc & ~wfull;
    assign wbin_next  = wbin + {{ADDR_W{1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign rbin_sync  = gray_to_bin(rptr_sync);
    assign level_next = wbin_next - rbin_sync;
    // Full when the write pointer has lapped the read pointer by exactly one pass.
    assign full_next  = (wgray_next == {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]});
    assign waddr      = wbin[ADDR_W-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= full_next;
            walmost_full <= (level_next >= AF_THR);
            wlevel       <= level_next;
            woverflow    <= winc & wfull;
        end
    end
endmodule

module async_fifo_rptr #(
    parameter int ADDR_W   = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rinc,
    input  logic [ADDR_W:0]   wptr_sync,
    output logic [ADDR_W:0]   rptr,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren,
    output logic              rempty,
    output logic              ralmost_empty,
    output logic [ADDR_W:0]   rlevel,
    output logic              runderflow
);
    localparam logic [ADDR_W:0] AE_THR = AE_LEVEL[ADDR_W:0];

    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] rbin_next;
    logic [ADDR_W:0] rgray_next;
    logic [ADDR_W:0] wbin_sync;
    logic [ADDR_W:0] level_next;
    logic            empty_next;

    function automatic logic [ADDR_W:0] gray_to_bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign ren        = rinc & ~rempty;
    assign rbin_next  = rbin + {{ADDR_W{1'b0}}, ren};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign wbin_sync  = gray_to_bin(wptr_sync);
    assign level_next = wbin_sync - rbin_next;
    assign empty_next = (rgray_next == wptr_sync);
    assign raddr      = rbin[ADDR_W-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbin_next;
            rptr          <= rgray_next;
            rempty        <= empty_next;
            ralmost_empty <= (level_next <= AE_THR);
            rlevel        <= level_next;
            runderflow    <= rinc & rempty;
        end
    end
endmodule

module async_fifo_param #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 0,
    parameter int AF_LEVEL    = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              winc,
    input  logic [DATA_W-1:0] wdata,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              woverflow,
    input  logic              rinc,
    output logic [DATA_W-1:0] rdata,
    output logic              rempty,
    output logic              ralmost_empty,
    output logic [ADDR_W:0]   rlevel,
    output logic              runderflow
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W:0]   wptr_sync;
    logic [ADDR_W:0]   rptr_sync;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic              wen;
    logic              ren;
    logic [DATA_W-1:0] mem [DEPTH];

    async_fifo_wptr #(
        .ADDR_W   (ADDR_W),
        .AF_LEVEL (AF_LEVEL)
    ) u_wptr (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr_sync    (rptr_sync),
        .wptr         (wptr),
        .waddr        (waddr),
        .wen          (wen),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    async_fifo_rptr #(
        .ADDR_W   (ADDR_W),
        .AE_LEVEL (AE_LEVEL)
    ) u_rptr (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .wptr_sync     (wptr_sync),
        .rptr          (rptr),
        .raddr         (raddr),
        .ren           (ren),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel),
        .runderflow    (runderflow)
    );

    // Read pointer into the write domain; cleared by the write-side reset.
    async_fifo_sync #(
        .WIDTH  (ADDR_W + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr),
        .q     (rptr_sync)
    );

    async_fifo_sync #(
        .WIDTH  (ADDR_W + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr),
        .q     (wptr_sync)
    );

    // Storage is deliberately not reset; flushing only rewinds the pointers.
    always_ff @(posedge wclk) begin
        if (wen) mem[waddr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = rempty ? '0 : mem[raddr];
        end else begin : g_reg_read
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n)  rdata <= '0;
                else if (ren) rdata <= mem[raddr];
            end
        end
    endgenerate
endmodule

// File: tb/tb_async_fifo_param.sv
// Self-checking bench: directed flag/level/latency cases on a registered-read and a
// fall-through instance, plus a randomized stream checked against a queue model.
`timescale 1ns/1ps

module tb_async_fifo_param;
    localparam int DEPTH = 16;
    localparam int SS    = 2;

    realtime w_half = 5.0;
    realtime r_half = 7.0;
    logic wclk = 1'b0;
    logic rclk = 1'b0;
    logic wrst_n = 1'b0;
    logic rrst_n = 1'b0;

    always #(w_half) wclk = ~wclk;
    always #(r_half) rclk = ~rclk;

    // Registered-read instance, default parameters.
    logic       d_winc, d_rinc;
    logic [7:0] d_wdata, d_rdata;
    logic       d_wfull, d_waf, d_wovf, d_rempty, d_rae, d_runf;
    logic [4:0] d_wlevel, d_rlevel;

    // Fall-through instance with almost-full at 12.
    logic       f_winc, f_rinc;
    logic [7:0] f_wdata, f_rdata;
    logic       f_wfull, f_waf, f_wovf, f_rempty, f_rae, f_runf;
    logic [4:0] f_wlevel, f_rlevel;

    async_fifo_param u_dut (
        .wclk (wclk), .wrst_n (wrst_n), .rclk (rclk), .rrst_n (rrst_n),
        .winc (d_winc), .wdata (d_wdata), .wfull (d_wfull), .walmost_full (d_waf),
        .wlevel (d_wlevel), .woverflow (d_wovf), .rinc (d_rinc), .rdata (d_rdata),
        .rempty (d_rempty), .ralmost_empty (d_rae), .rlevel (d_rlevel), .runderflow (d_runf)
    );

    async_fifo_param #(.FWFT(1), .AF_LEVEL(12)) u_fw (
        .wclk (wclk), .wrst_n (wrst_n), .rclk (rclk), .rrst_n (rrst_n),
        .winc (f_winc), .wdata (f_wdata), .wfull (f_wfull), .walmost_full (f_waf),
        .wlevel (f_wlevel), .woverflow (f_wovf), .rinc (f_rinc), .rdata (f_rdata),
        .rempty (f_rempty), .ralmost_empty (f_rae), .rlevel (f_rlevel), .runderflow (f_runf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic d_write(input logic [7:0] v);
        @(negedge wclk); d_winc = 1'b1; d_wdata = v;
        @(posedge wclk); #1; d_winc = 1'b0;
    endtask

    task automatic d_read();
        @(negedge rclk); d_rinc = 1'b1;
        @(posedge rclk); #1; d_rinc = 1'b0;
    endtask

    task automatic f_write(input logic [7:0] v);
        @(negedge wclk); f_winc = 1'b1; f_wdata = v;
        @(posedge wclk); #1; f_winc = 1'b0;
    endtask

    task automatic f_read();
        @(negedge rclk); f_rinc = 1'b1;
        @(posedge rclk); #1; f_rinc = 1'b0;
    endtask

    // Reference model for the streaming run: a plain queue of words in write order.
    logic [7:0] sq [$];
    int         tx_cnt, rx_cnt, rd_issued, wit, rit, n;
    logic       rd_pend;
    logic [7:0] rd_exp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        d_winc = 1'b0; d_rinc = 1'b0; d_wdata = '0;
        f_winc = 1'b0; f_rinc = 1'b0; f_wdata = '0;

        repeat (3) @(posedge wclk);
        #2; wrst_n = 1'b1; rrst_n = 1'b1;
        repeat (3) @(negedge rclk);
        check_eq("rst_rempty", d_rempty, 1);
        check_eq("rst_wfull", d_wfull, 0);
        check_eq("rst_wlevel", d_wlevel, 0);
        check_eq("rst_rlevel", d_rlevel, 0);
        check_eq("rst_rdata", d_rdata, 0);
        check_eq("rst_ralmost_empty", d_rae, 1);
        check_eq("rst_walmost_full", d_waf, 0);
        check_eq("rst_fw_rempty", f_rempty, 1);
        check_eq("rst_fw_rdata", f_rdata, 0);

        // Fill to full with no reads: read pointer stays at zero, so levels are exact.
        for (int i = 0; i < DEPTH; i++) begin
            d_write(8'(i));
            check_eq("fill_wfull", d_wfull, (i == DEPTH - 1));
            check_eq("fill_wlevel", d_wlevel, i + 1);
            check_eq("fill_walmost_full", d_waf, (i + 1 >= DEPTH - 2));
        end
        d_write(8'hAA);
        check_eq("ovf_pulse", d_wovf, 1);
        check_eq("ovf_wlevel", d_wlevel, DEPTH);
        @(posedge wclk); #1;
        check_eq("ovf_pulse_end", d_wovf, 0);

        repeat (12) @(negedge rclk);
        check_eq("full_rempty", d_rempty, 0);
        check_eq("full_rlevel", d_rlevel, DEPTH);
        check_eq("full_ralmost_empty", d_rae, 0);
        for (int i = 0; i < DEPTH; i++) begin
            d_read();
            check_eq("drain_rdata", d_rdata, i);
            check_eq("drain_rempty", d_rempty, (i == DEPTH - 1));
            check_eq("drain_rlevel", d_rlevel, DEPTH - 1 - i);
            check_eq("drain_ralmost_empty", d_rae, (DEPTH - 1 - i <= 2));
        end
        d_read();
        check_eq("unf_pulse", d_runf, 1);
        check_eq("unf_rdata_hold", d_rdata, 8'h0F);
        @(posedge rclk); #1;
        check_eq("unf_pulse_end", d_runf, 0);
        repeat (8) @(negedge wclk);
        check_eq("drained_wlevel", d_wlevel, 0);
        check_eq("drained_wfull", d_wfull, 0);

        // Fall-through: head visible without rinc, write-to-not-empty latency bounded.
        f_write(8'h5A);
        n = 0;
        while (n < 12) begin
            @(posedge rclk); n++; #1;
            if (!f_rempty) break;
        end
        check_eq("fw_empty_latency", (n >= SS + 1 && n <= SS + 2), 1);
        check_eq("fw_rdata_head", f_rdata, 8'h5A);
        check_eq("fw_rempty", f_rempty, 0);
        check_eq("fw_rlevel", f_rlevel, 1);
        f_read();
        check_eq("fw_pop_rempty", f_rempty, 1);
        check_eq("fw_pop_rdata", f_rdata, 0);

        repeat (10) @(negedge wclk);
        for (int i = 0; i < 12; i++) begin
            f_write(8'(8'h10 + i));
            check_eq("af_walmost_full", f_waf, (i == 11));
            check_eq("af_wlevel", f_wlevel, i + 1);
        end
        repeat (12) @(negedge rclk);
        check_eq("af_fw_head", f_rdata, 8'h10);
        f_read();
        check_eq("af_fw_next_head", f_rdata, 8'h11);
        n = 0;
        while (n < 12) begin
            @(posedge wclk); n++; #1;
            if (!f_waf) break;
        end
        check_eq("af_release_latency", (n >= SS + 1 && n <= SS + 2), 1);
        check_eq("af_wlevel_after_read", f_wlevel, 11);

        // Randomized streaming on the registered-read instance.
        w_half = 3.5; r_half = 5.5;
        repeat (4) @(negedge rclk);
        tx_cnt = 0; rx_cnt = 0; rd_issued = 0; wit = 0; rit = 0; rd_pend = 1'b0;
        fork
            begin
                while (tx_cnt < 1000 && wit < 40000) begin
                    @(negedge wclk); wit++;
                    check_eq("stream_woverflow", d_wovf, 0);
                    if (!d_wfull && $urandom_range(0, 3) != 0) begin
                        d_winc = 1'b1; d_wdata = 8'($urandom);
                        sq.push_back(d_wdata); tx_cnt++;
                    end else begin
                        d_winc = 1'b0;
                    end
                end
                @(negedge wclk); d_winc = 1'b0;
            end
            begin
                while (rx_cnt < 1000 && rit < 40000) begin
                    @(negedge rclk); rit++;
                    check_eq("stream_runderflow", d_runf, 0);
                    if (rd_pend) begin
                        check_eq("stream_data", d_rdata, rd_exp);
                        rx_cnt++; rd_pend = 1'b0;
                    end
                    if (!d_rempty && rd_issued < 1000 && sq.size() > 0 && $urandom_range(0, 3) != 0) begin
                        d_rinc = 1'b1; rd_exp = sq.pop_front(); rd_pend = 1'b1; rd_issued++;
                    end else begin
                        d_rinc = 1'b0;
                    end
                end
                d_rinc = 1'b0;
            end
        join
        check_eq("stream_words_received", rx_cnt, 1000);
        check_eq("stream_pointer_wraps", (rx_cnt / DEPTH >= 60), 1);
        repeat (20) @(negedge rclk);
        check_eq("stream_end_rempty", d_rempty, 1);
        check_eq("stream_end_rlevel", d_rlevel, 0);
        check_eq("stream_end_wlevel", d_wlevel, 0);
        check_eq("stream_end_wfull", d_wfull, 0);

        // Flush with words queued, then confirm the next write is the first read.
        for (int i = 0; i < 7; i++) d_write(8'(8'h40 + i));
        repeat (2) @(negedge rclk);
        #3; wrst_n = 1'b0; rrst_n = 1'b0;
        #1;
        check_eq("flush_rempty", d_rempty, 1);
        check_eq("flush_wlevel", d_wlevel, 0);
        check_eq("flush_rlevel", d_rlevel, 0);
        check_eq("flush_rdata", d_rdata, 0);
        check_eq("flush_wfull", d_wfull, 0);
        repeat (3) @(posedge wclk);
        #2; wrst_n = 1'b1; rrst_n = 1'b1;
        repeat (4) @(negedge rclk);
        d_write(8'h33);
        repeat (10) @(negedge rclk);
        check_eq("post_flush_rempty", d_rempty, 0);
        check_eq("post_flush_rlevel", d_rlevel, 1);
        d_read();
        check_eq("post_flush_rdata", d_rdata, 8'h33);
        check_eq("post_flush_empty_again", d_rempty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
